// File: rtl/instr_decode_queue.sv
// instr_decode_queue: decodes RV32I words at push time into a DEPTH-entry FIFO
// feeding execute over valid/ready.
module instr_decode_queue #(
    parameter int XLEN = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]   rp, wp;
    logic [AW:0]     cnt;
    logic [XLEN-1:0] pc_q  [DEPTH];
    logic [31:0]     ins_q [DEPTH];
    logic [2:0]      fmt_q [DEPTH];
    logic [XLEN-1:0] imm_q [DEPTH];
    logic [DEPTH-1:0] ill_q;
    logic [2:0]      fmt;
    logic [31:0]     imm32;
    logic            push, pop;

    // Every supported opcode ends in 2'b11, so the low-bit check falls out of the default arm.
    always_comb begin
        fmt = 3'd7;
        imm32 = '0;
        case (in_instr[6:0])
            7'b0110011: fmt = 3'd0;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                fmt = 3'd1;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                fmt = 3'd2;
                imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                fmt = 3'd3;
                imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                fmt = 3'd4;
                imm32 = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                fmt = 3'd5;
                imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    assign in_ready = cnt != (AW+1)'(DEPTH);
    assign out_valid = cnt != '0;
    assign push = in_valid && in_ready;
    assign pop = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp <= '0;
            wp <= '0;
            cnt <= '0;
            ill_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i] <= '0;
                ins_q[i] <= '0;
                fmt_q[i] <= '0;
                imm_q[i] <= '0;
            end
        end else if (flush) begin
            rp <= '0;
            wp <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                pc_q[wp] <= in_pc;
                ins_q[wp] <= in_instr;
                fmt_q[wp] <= fmt;
                imm_q[wp] <= XLEN'($signed(imm32));
                ill_q[wp] <= fmt == 3'd7;
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign out_pc = pc_q[rp];
    assign {out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode} = ins_q[rp];
    assign out_fmt = fmt_q[rp];
    assign out_imm = imm_q[rp];
    assign out_illegal = ill_q[rp];
endmodule
